// File: rtl/ahb_pkg.sv
// Shared encodings and helpers for the three-master AHB arbiter.
// Master encodings match the address/control mux select.
package ahb_pkg;

    typedef enum logic [1:0] {
        MASTER1 = 2'b00,
        MASTER2 = 2'b01,
        MASTER3 = 2'b10
    } master_e;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    // Grant vector bit order is {master3, master2, master1}.
    function automatic logic [2:0] master_onehot(input logic [1:0] m);
        case (m)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Next master in rotation order 1 -> 2 -> 3 -> 1.
    function automatic logic [1:0] rr_next(input logic [1:0] m);
        return (m == 2'b10) ? 2'b00 : m + 2'b01;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface ahb_bus_arbiter_if;

    logic       hbusreq1;
    logic       hbusreq2;
    logic       hbusreq3;
    logic       hlock1;
    logic       hlock2;
    logic       hlock3;
    logic [1:0] htrans;
    logic       hready;
    logic       hgrant1;
    logic       hgrant2;
    logic       hgrant3;
    logic [1:0] hmaster;
    logic [1:0] hmaster_d;
    logic       hmastlock;

    modport master (
        output hbusreq1, hbusreq2, hbusreq3,
        output hlock1, hlock2, hlock3,
        output htrans, hready,
        input  hgrant1, hgrant2, hgrant3,
        input  hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq1, hbusreq2, hbusreq3,
        input  hlock1, hlock2, hlock3,
        input  htrans, hready,
        output hgrant1, hgrant2, hgrant3,
        output hmaster, hmaster_d, hmastlock
    );

endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first eligible requester after 'last',
// wrapping 3 -> 1. Masters flagged in 'excl' are skipped.
module ahb_rr_pick
    import ahb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic [2:0] excl,
    output logic [1:0] win,
    output logic       any_req
);

    logic [2:0] elig;
    logic [1:0] idx;

    assign elig = req & ~excl;

    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred; blocking assignment is correct
    // because idx is reused as a running cursor within the same evaluation.
    always_comb begin
        win     = MASTER1;
        any_req = 1'b0;
        idx     = rr_next(last);
        for (int i = 0; i < 3; i++) begin
            if (!any_req && elig[idx]) begin
                win     = idx;
                any_req = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Three-master AHB arbiter: round-robin with lock, hready-gated handover and a
// hold-count starvation guard. Drives address-phase and data-phase owner selects.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter master_e DEFAULT_MASTER = MASTER1,
    parameter int      MAX_HOLD       = 16,
    parameter int      CNT_W          = 5
) (
    input  logic                hclk,
    input  logic                hresetn,
    ahb_bus_arbiter_if.slave    bus
);

    master_e            grant_q;
    master_e            grant_d;
    master_e            last_q;
    master_e            last_d;
    master_e            hmaster_q;
    master_e            hmaster_d_q;
    master_e            winner;
    logic               hmastlock_q;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_d;

    logic [2:0]         req;
    logic [2:0]         lock;
    logic [2:0]         owner_vec;
    logic [2:0]         excl;
    logic [1:0]         win;
    logic               any_req;
    logic               owner_lock;
    logic               window;
    logic               beat;
    logic               hold_full;
    logic               others_req;

    assign req       = {bus.hbusreq3, bus.hbusreq2, bus.hbusreq1};
    assign lock      = {bus.hlock3, bus.hlock2, bus.hlock1};
    assign owner_vec = master_onehot(grant_q);

    assign owner_lock = lock[grant_q];
    assign window     = bus.hready && !owner_lock && (bus.htrans != HTRANS_BUSY);
    assign beat       = (bus.htrans == HTRANS_NSEQ) || (bus.htrans == HTRANS_SEQ);
    assign hold_full  = (hold_cnt >= CNT_W'(MAX_HOLD));
    assign others_req = |(req & ~owner_vec);

    // A long-running owner steps aside only when someone else is waiting.
    assign excl = (hold_full && others_req) ? owner_vec : 3'b000;

    ahb_rr_pick u_pick (
        .req     (req),
        .last    (last_q),
        .excl    (excl),
        .win     (win),
        .any_req (any_req)
    );

    assign winner = any_req ? master_e'(win) : DEFAULT_MASTER;

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_cnt;
        if (bus.hready) begin
            if (window && (winner != grant_q)) begin
                grant_d = winner;
                last_d  = winner;
                hold_d  = '0;
            end else if (beat && !hold_full) begin
                hold_d = hold_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block and
    // every register, including the rotation pointer, gets an explicit value;
    // sequential state always uses non-blocking assignment so all registers
    // sample pre-edge values.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            grant_q     <= DEFAULT_MASTER;
            last_q      <= MASTER3;
            hold_cnt    <= '0;
            hmaster_q   <= DEFAULT_MASTER;
            hmaster_d_q <= DEFAULT_MASTER;
            hmastlock_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            hold_cnt <= hold_d;
            if (bus.hready) begin
                hmaster_q   <= grant_q;
                hmaster_d_q <= hmaster_q;
                hmastlock_q <= owner_lock;
            end
        end
    end

    assign {bus.hgrant3, bus.hgrant2, bus.hgrant1} = owner_vec;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmaster_d = hmaster_d_q;
    assign bus.hmastlock = hmastlock_q;

    grant_legal: assert property (@(posedge hclk) disable iff (!hresetn)
        grant_q != 2'b11);

    owner_legal: assert property (@(posedge hclk) disable iff (!hresetn)
        (hmaster_q != 2'b11) && (hmaster_d_q != 2'b11));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a rule model.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int MAX_HOLD = 4;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;

    always #5 hclk = ~hclk;

    ahb_bus_arbiter_if bus ();

    ahb_bus_arbiter #(
        .DEFAULT_MASTER (MASTER1),
        .MAX_HOLD       (MAX_HOLD),
        .CNT_W          (3)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: masters numbered 1..3, bus encoding is number-1.
    int m_grant, m_last, m_hold, m_am, m_dm;
    bit m_lock;
    bit m_valid = 1'b0;

    function automatic bit req_of(input int m);
        case (m)
            1:       return bus.hbusreq1;
            2:       return bus.hbusreq2;
            default: return bus.hbusreq3;
        endcase
    endfunction

    function automatic bit lock_of(input int m);
        case (m)
            1:       return bus.hlock1;
            2:       return bus.hlock2;
            default: return bus.hlock3;
        endcase
    endfunction

    function automatic int model_pick();
        bit starve = 1'b0;
        for (int m = 1; m <= 3; m++)
            if (m != m_grant && req_of(m) && m_hold >= MAX_HOLD) starve = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            int c = (m_last + k - 1) % 3 + 1;
            if (req_of(c) && !(starve && c == m_grant)) return c;
        end
        return 1;
    endfunction

    always @(posedge hclk) begin
        if (!hresetn) begin
            m_grant = 1; m_last = 3; m_hold = 0; m_am = 1; m_dm = 1; m_lock = 1'b0;
            m_valid = 1'b1;
        end else if (bus.hready) begin
            int  w;
            bit  is_beat;
            bit  open;
            is_beat = bus.htrans[1];
            open    = !lock_of(m_grant) && (bus.htrans != HTRANS_BUSY);
            w       = open ? model_pick() : m_grant;
            m_dm    = m_am;
            m_am    = m_grant;
            m_lock  = lock_of(m_grant);
            if (w != m_grant) begin
                m_grant = w; m_last = w; m_hold = 0;
            end else if (is_beat && m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    end

    function automatic logic [2:0] grant_vec();
        return {bus.hgrant3, bus.hgrant2, bus.hgrant1};
    endfunction

    always @(negedge hclk) begin
        if (m_valid) begin
            check("cyc_hgrant",    32'(grant_vec()),     32'(1 << (m_grant - 1)));
            check("cyc_hmaster",   32'(bus.hmaster),     32'(m_am - 1));
            check("cyc_hmaster_d", 32'(bus.hmaster_d),   32'(m_dm - 1));
            check("cyc_hmastlock", 32'(bus.hmastlock),   32'(m_lock));
            check("cyc_hold_cnt",  32'(dut.hold_cnt),    32'(m_hold));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] r);
        {bus.hbusreq3, bus.hbusreq2, bus.hbusreq1} = r;
    endtask

    task automatic set_lock(input logic [2:0] l);
        {bus.hlock3, bus.hlock2, bus.hlock1} = l;
    endtask

    initial begin
        set_req(3'b000);
        set_lock(3'b000);
        bus.htrans = HTRANS_IDLE;
        bus.hready = 1'b1;
        hresetn    = 1'b0;

        // T1 reset
        step(2);
        check("t1_hgrant",    32'(grant_vec()),   32'h1);
        check("t1_hmaster",   32'(bus.hmaster),   32'h0);
        check("t1_hmaster_d", 32'(bus.hmaster_d), 32'h0);
        check("t1_hmastlock", 32'(bus.hmastlock), 32'h0);
        hresetn = 1'b1;

        // T2 rotation: M1 holds until the guard trips, then strict rotation
        set_req(3'b111);
        bus.htrans = HTRANS_NSEQ;
        step(4);
        check("t2_grant_e4", 32'(grant_vec()), 32'h1);
        step(1);
        check("t2_grant_e5", 32'(grant_vec()), 32'h2);
        step(1);
        check("t2_grant_e6",   32'(grant_vec()),   32'h4);
        check("t2_hmaster_e6", 32'(bus.hmaster),   32'h1);
        step(1);
        check("t2_grant_e7",     32'(grant_vec()),   32'h1);
        check("t2_hmaster_d_e7", 32'(bus.hmaster_d), 32'h1);
        step(1);
        check("t2_grant_e8", 32'(grant_vec()), 32'h2);

        // T3 wait states freeze grant and both owner selects
        set_req(3'b110);
        bus.hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t3_grant_frozen",     32'(grant_vec()),   32'h2);
            check("t3_hmaster_frozen",   32'(bus.hmaster),   32'h0);
            check("t3_hmaster_d_frozen", 32'(bus.hmaster_d), 32'h2);
        end
        bus.hready = 1'b1;
        step(1);
        check("t3_grant_adv",     32'(grant_vec()),   32'h4);
        check("t3_hmaster_adv",   32'(bus.hmaster),   32'h1);
        check("t3_hmaster_d_adv", 32'(bus.hmaster_d), 32'h0);

        // T4 lock: M1 locked for 6 beats while M2 waits
        set_req(3'b011);
        set_lock(3'b001);
        step(1);
        check("t4_grant_m1", 32'(grant_vec()), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("t4_grant_held", 32'(grant_vec()),   32'h1);
            check("t4_hmastlock",  32'(bus.hmastlock), 32'h1);
        end
        set_lock(3'b000);
        step(1);
        check("t4_grant_m2",     32'(grant_vec()),   32'h2);
        check("t4_hmastlock_lo", 32'(bus.hmastlock), 32'h0);

        // T5 starvation guard: M1 streams SEQ from reset while M2 requests
        hresetn = 1'b0;
        step(1);
        hresetn    = 1'b1;
        bus.htrans = HTRANS_SEQ;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check("t5_grant_m1", 32'(grant_vec()),  32'h1);
            check("t5_hold",     32'(dut.hold_cnt), 32'(i));
        end
        step(1);
        check("t5_grant_m2",  32'(grant_vec()),  32'h2);
        check("t5_hold_zero", 32'(dut.hold_cnt), 32'h0);

        // T6 idle bus falls back to the default master
        set_req(3'b100);
        step(1);
        check("t6_grant_m3", 32'(grant_vec()), 32'h4);
        set_req(3'b000);
        step(1);
        check("t6_grant_default", 32'(grant_vec()), 32'h1);
        check("t6_hmaster_m3",    32'(bus.hmaster), 32'h2);

        // Randomized traffic, compared each cycle against the model
        for (int i = 0; i < 3000; i++) begin
            set_req(3'($urandom));
            set_lock({($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 9) == 0)});
            bus.htrans = 2'($urandom);
            bus.hready = ($urandom_range(0, 3) != 0);
            hresetn    = ($urandom_range(0, 99) != 0);
            step(1);
        end
        hresetn = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
